zstr_src: RTL
=============

# zstr_src

Paced stream source for the z stream protocol. Sits directly upstream of the stream drain and drives its `z_vld`/`z_bus`, honouring `z_rdy` backpressure. Entries are pushed through a load port into a QL-deep queue. Each entry carries a bus word and an idle-gap count, so benches and traffic generators can produce exact, repeatable valid/idle patterns in synthesizable form.

## Interface
- `BW`, default 1: bus width.
- `XZ`, default `1'bx`: value driven on `z_bus` while `z_vld` is low.
- `QL`, default 4: queue depth in entries; any value ≥1, power of two not required.
- `DW`, default 8: idle-gap field width.
- `QW`, default `$clog2(QL+1)`: occupancy count width.
- Clocking and reset (decided): one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  synchronous active-high reset.
- `q_vld`  in  1  load request.
- `q_dly`  in  DW  idle cycles to insert before this entry's transfer.
- `q_bus`  in  BW  bus word.
- `q_rdy`  out  1  queue can accept.
- `q_cnt`  out  QW  current queue occupancy.
- `z_vld`  out  1  stream transfer valid.
- `z_bus`  out  BW  stream bus.
- `z_rdy`  in  1  stream transfer ready.

## Operation
- **Push:** `q_vld & q_rdy` writes `{q_dly, q_bus}` at the write pointer.
  - `q_rdy = (q_cnt < QL)`, registered-state only; no combinational path from `z_rdy` or `q_vld`.
- **Pop:** stream transfer `z_trn = z_vld & z_rdy` frees the head entry.
- **Pointers and count:**
  - Pointers wrap modulo QL.
  - `q_cnt` adds 1 on push and subtracts 1 on pop; a simultaneous push and pop leaves it unchanged.
- **FSM states:** IDLE, WAIT, SEND.
  - IDLE: `z_vld=0`. If `q_cnt>0`, load the gap counter from the head's `dly`. Go to SEND if `dly==0`, otherwise to WAIT.
  - WAIT: `z_vld=0`. Decrement the gap counter each cycle. Go to SEND on the cycle the counter reaches 1.
  - SEND: `z_vld=1`, `z_bus` = head bus.
    - On `z_trn`, if the queue still holds another entry (count after pop >0), load its `dly` and go to SEND (`dly==0`) or WAIT.
    - On `z_trn` with no further entry, go to IDLE.
    - Without `z_trn`, stay in SEND.
- **Protocol rules:**
  - `z_vld` never deasserts without a transfer.
  - `z_bus` is stable while `z_vld & !z_rdy`.
  - `z_bus = XZ` whenever `z_vld=0`.
- **Ordering:** strict FIFO; data is never dropped or duplicated.

## Timing
- **Reset values:** `z_vld=0`, `z_bus=XZ`, `q_rdy=1`, `q_cnt=0`, FSM=IDLE, pointers=0, gap counter=0. Queue contents are discarded.
- **Reset mid-operation:** `rst` in WAIT or SEND forces reset values on the next cycle. A push in the same cycle as `rst` is ignored.
- **First-entry latency:** push accepted in cycle 0 with `dly=N` gives `z_vld` high from cycle 2+N.
- **Back-to-back:** after a transfer in cycle t, the next entry with `dly=N` is valid from cycle t+1+N. With `dly=0` this is full throughput, one transfer per cycle.
- **Empty-queue push:** a push into an empty queue while in SEND cannot happen, since SEND implies `q_cnt≥1`. A push in the same cycle as the last pop is seen by IDLE on the following cycle.
- **Full queue:** `q_rdy=0` even if a pop occurs in the same cycle; it reasserts the cycle after the pop.
- **Gap width:** `dly` up to `2**DW-1`; the gap counter is DW bits and does not wrap.

## Structure
- Shared package `zstr_pkg` holds `typedef enum logic [1:0] {IDLE, WAIT, SEND} zstr_src_state_t`.
- Sub-module `zstr_fifo` (params BW+DW, QL) contains storage, pointers, count, `q_rdy`, and the head read port.
- `zstr_src` contains the FSM, the gap counter and the output muxing.

## Test plan
- **Reset:** assert `rst` 2 cycles, then release. Required: `z_vld=0`, `z_bus=XZ`, `q_rdy=1`, `q_cnt=0` throughout and after.
- **Single entry, no gap:** push `{dly=0, bus=0x5}` in cycle 0 with `z_rdy=1`. Required: `z_vld=1`, `z_bus=0x5` in cycle 2 only; `q_cnt` back to 0 in cycle 3.
- **Full throughput:** push 3 entries with `dly=0` (0xA, 0xB, 0xC) in cycles 0–2 with `z_rdy=1`. Required: `z_vld` high cycles 2–4 carrying 0xA, 0xB, 0xC.
- **Gap insertion:** push `{3, 0x1}` then `{2, 0x2}` with `z_rdy=1`. Required: `z_vld` high in cycle 5, then exactly 2 idle cycles, then high in cycle 8.
- **Backpressure and full:** QL=4, push 5 entries with `z_rdy=0`. Required:
  - `q_rdy=0` after the 4th push, and the 5th push is stalled.
  - `z_vld` held with `z_bus` stable.
  - After releasing `z_rdy`, all 5 words emerge in order.
  - Repeating for 10 entries checks wrap-around.
- **Reset mid-SEND:** assert `rst` while in SEND with 3 entries queued and `z_rdy=0`. Required: next cycle `z_vld=0`, `q_cnt=0`; no stale word appears afterwards.

Source files
------------

// File: rtl/zstr_pkg.sv
// Shared types for the z stream source: FSM state encoding.
package zstr_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, SEND} zstr_src_state_t;

endpackage

// File: rtl/zstr_fifo.sv
// Entry queue for zstr_src: storage, wrapping pointers, occupancy and head/next read ports.
// o_next exposes only the upper field of the entry after the head (bits W-1 down to NLO).
module zstr_fifo #(
  parameter int W   = 9,
  parameter int QL  = 4,
  parameter int QW  = $clog2(QL + 1),
  parameter int NLO = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic [W-1:0]    i_data,
  input  logic            i_pop,
  output logic            o_rdy,
  output logic [QW-1:0]   o_cnt,
  output logic [W-1:0]    o_head,
  output logic [W-NLO-1:0] o_next
);

  localparam int PW = (QL > 1) ? $clog2(QL) : 1;
  localparam logic [PW-1:0] LAST = PW'(QL - 1);

  logic [W-1:0]  r_mem [QL];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_rd_inc;
  logic [QW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;
  logic [W-1:0]  w_next_entry;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign o_rdy    = (r_cnt < QW'(QL));
  assign w_push   = i_push & o_rdy;
  assign w_pop    = i_pop & (r_cnt != '0);
  assign w_rd_inc = ptr_inc(r_rd_ptr);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= w_rd_inc;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + QW'(1);
        2'b01:   r_cnt <= r_cnt - QW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_next_entry = r_mem[w_rd_inc];
  assign o_cnt  = r_cnt;
  assign o_head = r_mem[r_rd_ptr];
  assign o_next = w_next_entry[W-1:NLO];

endmodule

// File: rtl/zstr_src.sv
// Paced z stream source: queued {gap, word} entries are emitted in order,
// each preceded by its programmed number of idle cycles, honouring z_rdy.
module zstr_src
  import zstr_pkg::*;
#(
  parameter int            BW = 1,
  parameter logic [BW-1:0] XZ = {BW{1'bx}},
  parameter int            QL = 4,
  parameter int            DW = 8,
  parameter int            QW = $clog2(QL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          q_vld,
  input  logic [DW-1:0] q_dly,
  input  logic [BW-1:0] q_bus,
  output logic          q_rdy,
  output logic [QW-1:0] q_cnt,
  output logic          z_vld,
  output logic [BW-1:0] z_bus,
  input  logic          z_rdy
);

  localparam int W = BW + DW;

  zstr_src_state_t r_state, w_state_next;
  logic [DW-1:0]   r_gap, w_gap_next;
  logic [W-1:0]    w_head;
  logic [DW-1:0]   w_next_dly;
  logic [DW-1:0]   w_head_dly;
  logic [BW-1:0]   w_head_bus;
  logic            w_trn;

  zstr_fifo #(
    .W   (W),
    .QL  (QL),
    .QW  (QW),
    .NLO (BW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (q_vld),
    .i_data ({q_dly, q_bus}),
    .i_pop  (w_trn),
    .o_rdy  (q_rdy),
    .o_cnt  (q_cnt),
    .o_head (w_head),
    .o_next (w_next_dly)
  );

  assign w_head_dly = w_head[W-1:BW];
  assign w_head_bus = w_head[BW-1:0];
  assign w_trn      = (r_state == SEND) & z_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_next;
      r_gap   <= w_gap_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap;
    z_vld        = 1'b0;
    z_bus        = XZ;
    case (r_state)
      IDLE: begin
        if (q_cnt != '0) begin
          w_gap_next   = w_head_dly;
          w_state_next = (w_head_dly == '0) ? SEND : WAIT;
        end
      end
      WAIT: begin
        if (r_gap != '0) w_gap_next = r_gap - DW'(1);
        if (r_gap <= DW'(1)) w_state_next = SEND;
      end
      SEND: begin
        z_vld = 1'b1;
        z_bus = w_head_bus;
        // An entry pushed during the last pop is not yet visible; IDLE picks it up.
        if (z_rdy) begin
          if (q_cnt > QW'(1)) begin
            w_gap_next   = w_next_dly;
            w_state_next = (w_next_dly == '0) ? SEND : WAIT;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule
